simo_unpack_fifo: RTL and testbench

SIMO_UNPACK_FIFO -- requirements
Module: simo_unpack_fifo

---
 rtl/simo_unpack_fifo.sv | 110 +++++++++++
 tb/tb_simo_unpack_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/simo_unpack_fifo.sv
// Single-input, multi-output unpacking FIFO: packed words are split into 1/2/4
// zero-extended elements on write; up to DATA_LENGTH elements leave per pop.
module simo_unpack_fifo #(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DATA_LENGTH = 8,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_clear,
  input  logic                              i_write_en,
  input  logic [DATA_WIDTH-1:0]             i_data,
  input  logic [1:0]                        i_p_mode,
  input  logic                              i_pop_en,
  output logic [DATA_LENGTH*DATA_WIDTH-1:0] o_data,
  output logic [DATA_LENGTH-1:0]            o_valid,
  output logic                              o_pop_valid,
  output logic                              o_empty,
  output logic                              o_full,
  output logic [ADDR_WIDTH:0]               o_count
);

  localparam int unsigned CW   = ADDR_WIDTH + 1;
  localparam int unsigned MAXN = 4;
  localparam int unsigned EW2  = DATA_WIDTH / 2;
  localparam int unsigned EW4  = DATA_WIDTH / 4;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [CW-1:0]         r_count;

  logic [CW-1:0]         w_n;
  logic [CW-1:0]         w_free;
  logic [CW-1:0]         w_pop_n;
  logic [CW-1:0]         w_add;
  logic [CW-1:0]         w_sub;
  logic                  w_wr_acc;
  logic                  w_pop_acc;
  logic                  w_flush;
  logic [DATA_WIDTH-1:0] w_elem [MAXN];

  // Elements per word and the unpacked, zero-extended elements of i_data
  always_comb begin
    w_n = CW'(1);
    for (int k = 0; k < MAXN; k++) w_elem[k] = '0;
    case (i_p_mode)
      2'b01: begin
        w_n = CW'(2);
        for (int k = 0; k < 2; k++) w_elem[k] = DATA_WIDTH'(i_data[k*EW2 +: EW2]);
      end
      2'b10: begin
        w_n = CW'(4);
        for (int k = 0; k < 4; k++) w_elem[k] = DATA_WIDTH'(i_data[k*EW4 +: EW4]);
      end
      default: w_elem[0] = i_data;
    endcase
  end

  // Status and acceptance, all from start-of-cycle occupancy
  always_comb begin
    w_free    = CW'(DEPTH) - r_count;
    o_full    = (w_free < w_n);
    o_empty   = (r_count == '0);
    w_flush   = i_rst | i_clear;
    w_wr_acc  = i_write_en & ~o_full;
    w_pop_acc = i_pop_en & ~o_empty;
    w_pop_n   = (r_count > CW'(DATA_LENGTH)) ? CW'(DATA_LENGTH) : r_count;
    w_add     = w_wr_acc  ? w_n     : '0;
    w_sub     = w_pop_acc ? w_pop_n : '0;
  end

  assign o_count = r_count;

  // Storage is intentionally not reset; occupancy tracking guards against stale reads
  always_ff @(posedge i_clk) begin
    if (w_wr_acc && !w_flush) begin
      for (int k = 0; k < MAXN; k++) begin
        if (CW'(k) < w_n) r_mem[r_wptr + ADDR_WIDTH'(k)] <= w_elem[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      o_data      <= '0;
      o_valid     <= '0;
      o_pop_valid <= 1'b0;
    end else begin
      r_count     <= r_count + w_add - w_sub;
      o_pop_valid <= w_pop_acc;
      if (w_wr_acc) r_wptr <= r_wptr + ADDR_WIDTH'(w_n);
      if (w_pop_acc) r_rptr <= r_rptr + ADDR_WIDTH'(w_pop_n);
      for (int j = 0; j < DATA_LENGTH; j++) begin
        if (w_pop_acc && (CW'(j) < w_pop_n)) begin
          o_data[j*DATA_WIDTH +: DATA_WIDTH] <= r_mem[r_rptr + ADDR_WIDTH'(j)];
          o_valid[j]                         <= 1'b1;
        end else begin
          o_data[j*DATA_WIDTH +: DATA_WIDTH] <= '0;
          o_valid[j]                         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_simo_unpack_fifo.sv
// Bench for simo_unpack_fifo: directed scenarios plus random traffic against a
// queue-based element model.
module tb_simo_unpack_fifo;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned DW    = 8;
  localparam int unsigned DL    = 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_clear = 1'b0;
  logic              i_write_en = 1'b0;
  logic [DW-1:0]     i_data = '0;
  logic [1:0]        i_p_mode = 2'b00;
  logic              i_pop_en = 1'b0;
  logic [DL*DW-1:0]  o_data;
  logic [DL-1:0]     o_valid;
  logic              o_pop_valid;
  logic              o_empty;
  logic              o_full;
  logic [AW:0]       o_count;

  simo_unpack_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .DATA_LENGTH(DL)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_write_en(i_write_en),
    .i_data(i_data), .i_p_mode(i_p_mode), .i_pop_en(i_pop_en), .o_data(o_data),
    .o_valid(o_valid), .o_pop_valid(o_pop_valid), .o_empty(o_empty),
    .o_full(o_full), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0]    mq[$];
  logic [DL*DW-1:0] exp_data;
  logic [DL-1:0]    exp_valid;
  logic             exp_pv;
  logic             exp_full_pre, exp_empty_pre;
  logic             obs_full, obs_empty;

  // Drive one cycle, sample pre-edge flags, advance the element-queue model
  task automatic step(input logic we, input logic [7:0] d, input logic [1:0] m,
                      input logic pop, input logic clr, input logic rst);
    int cnt, n, p, ew;
    i_write_en = we; i_data = d; i_p_mode = m; i_pop_en = pop;
    i_clear = clr; i_rst = rst;
    #1;
    obs_full = o_full; obs_empty = o_empty;
    cnt = mq.size();
    n   = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
    ew  = 8 / n;
    exp_full_pre  = ((DEPTH - cnt) < n);
    exp_empty_pre = (cnt == 0);
    @(posedge i_clk);
    exp_data = '0; exp_valid = '0; exp_pv = 1'b0;
    if (rst || clr) begin
      mq.delete();
    end else begin
      p = pop ? ((cnt < DL) ? cnt : DL) : 0;
      exp_pv = (p > 0);
      for (int j = 0; j < p; j++) begin
        exp_data[j*DW +: DW] = mq.pop_front();
        exp_valid[j] = 1'b1;
      end
      if (we && !exp_full_pre)
        for (int k = 0; k < n; k++) mq.push_back(8'((int'(d) >> (k*ew)) & ((1 << ew) - 1)));
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 8'h5A, 2'b00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (o_data !== '0 || o_valid !== '0 || o_pop_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got data=%h valid=%h pv=%b", o_data, o_valid, o_pop_valid);
    end
    n_tests++;
    if (o_count !== '0 || o_empty !== 1'b1 || o_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_status got count=%0d empty=%b full=%b exp 0/1/0", o_count, o_empty, o_full);
    end
  endtask

  task automatic test_8x8();
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i * 8'h11), 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o_data !== 64'h8877665544332211 || o_valid !== 8'hFF || o_empty !== 1'b1) begin
      n_fail++; $display("FAIL 8x8_pop got data=%h valid=%h empty=%b exp 8877665544332211/ff/1", o_data, o_valid, o_empty);
    end
  endtask

  task automatic test_4x4_2x2();
    step(1'b1, 8'h21, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h43, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h65, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h87, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 2'b01, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o_data !== 64'h0807060504030201 || o_valid !== 8'hFF) begin
      n_fail++; $display("FAIL 4x4_pop got data=%h valid=%h exp 0807060504030201/ff", o_data, o_valid);
    end
    step(1'b1, 8'hE4, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hE4, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o_data !== 64'h0302010003020100 || o_valid !== 8'hFF) begin
      n_fail++; $display("FAIL 2x2_pop got data=%h valid=%h exp 0302010003020100/ff", o_data, o_valid);
    end
  endtask

  task automatic test_partial();
    step(1'b1, 8'hAA, 2'b11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hCC, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o_data !== 64'h0000000000CCBBAA || o_valid !== 8'h07 || o_pop_valid !== 1'b1) begin
      n_fail++; $display("FAIL partial_pop got data=%h valid=%h pv=%b exp ccbbaa/07/1", o_data, o_valid, o_pop_valid);
    end
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o_pop_valid !== 1'b0 || o_valid !== '0 || o_data !== '0) begin
      n_fail++; $display("FAIL empty_pop got pv=%b valid=%h data=%h exp all 0", o_pop_valid, o_valid, o_data);
    end
  endtask

  task automatic test_full_wrap();
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 2'b00, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (obs_full !== 1'b1 || o_count !== 6'd32) begin
      n_fail++; $display("FAIL full_drop got full=%b count=%0d exp 1/32", obs_full, o_count);
    end
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o_data !== 64'h0706050403020100) begin
      n_fail++; $display("FAIL wrap_pop0 got %h exp 0706050403020100", o_data);
    end
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o_data !== 64'h1F1E1D1C1B1A1918) begin
      n_fail++; $display("FAIL wrap_pop3 got %h exp 1f1e1d1c1b1a1918", o_data);
    end
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o_data !== 64'h4746454443424140 || o_count !== '0) begin
      n_fail++; $display("FAIL wrap_pop4 got %h count=%0d exp 4746454443424140/0", o_data, o_count);
    end
    for (int i = 0; i < 30; i++) step(1'b1, 8'(i), 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hE4, 2'b10, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (obs_full !== 1'b1 || o_count !== 6'd30) begin
      n_fail++; $display("FAIL full_2x2_at30 got full=%b count=%0d exp 1/30", obs_full, o_count);
    end
    step(1'b1, 8'h21, 2'b01, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (obs_full !== 1'b0 || o_count !== 6'd32 || o_full !== 1'b1) begin
      n_fail++; $display("FAIL fill_4x4_at30 got prefull=%b count=%0d full=%b exp 0/32/1", obs_full, o_count, o_full);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hE4, 2'b10, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o_data !== 64'h1716151413121110 || o_valid !== 8'hFF || o_count !== 6'd4) begin
      n_fail++; $display("FAIL simul_pop got data=%h valid=%h count=%0d exp 1716151413121110/ff/4", o_data, o_valid, o_count);
    end
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (o_data !== 64'h0000000003020100 || o_valid !== 8'h0F) begin
      n_fail++; $display("FAIL simul_after got data=%h valid=%h exp 03020100/0f", o_data, o_valid);
    end
  endtask

  task automatic test_clear_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 2'b00, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (o_data !== '0 || o_valid !== '0 || o_pop_valid !== 1'b0 || o_count !== '0 || o_empty !== 1'b1) begin
      n_fail++; $display("FAIL clear got data=%h valid=%h pv=%b count=%0d empty=%b", o_data, o_valid, o_pop_valid, o_count, o_empty);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (o_pop_valid !== 1'b0 || o_valid !== '0 || o_count !== '0 || o_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_midpop got pv=%b valid=%h count=%0d empty=%b", o_pop_valid, o_valid, o_count, o_empty);
    end
  endtask

  task automatic test_random();
    logic we, pop, clr;
    for (int c = 0; c < 500; c++) begin
      we  = ($urandom_range(0, 3) != 0);
      pop = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 79) == 0);
      step(we, 8'($urandom), 2'($urandom), pop, clr, 1'b0);
      n_tests++;
      if (o_data !== exp_data || o_valid !== exp_valid || o_pop_valid !== exp_pv) begin
        n_fail++; $display("FAIL rand_pop c=%0d got %h/%h/%b exp %h/%h/%b", c, o_data, o_valid, o_pop_valid, exp_data, exp_valid, exp_pv);
      end
      n_tests++;
      if (o_count !== (AW+1)'(mq.size()) || obs_full !== exp_full_pre || obs_empty !== exp_empty_pre) begin
        n_fail++; $display("FAIL rand_status c=%0d got count=%0d full=%b empty=%b exp %0d/%b/%b", c, o_count, obs_full, obs_empty, mq.size(), exp_full_pre, exp_empty_pre);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8x8();
    test_4x4_2x2();
    test_partial();
    test_full_wrap();
    test_simultaneous();
    test_clear_reset();
    test_random();
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
